// File: rtl/trim_pkg.sv
// Shared types for the trim sweep generator: FSM states, tick phases, step normalisation.
package trim_pkg;

   typedef enum logic [2:0] {
      TS_IDLE,
      TS_LOAD,
      TS_SHIFT,
      TS_LATCH,
      TS_SETTLE
   } ts_state_e;

   // Phase A: ENCLK low and DOUT update. Phase B: ENCLK high.
   localparam logic PH_A = 1'b0;
   localparam logic PH_B = 1'b1;

   // A zero step would never advance, so it is promoted to 1.
   function automatic logic [15:0] norm_step(input logic [15:0] step);
      return (step == 16'd0) ? 16'd1 : step;
   endfunction

endpackage

// File: rtl/trim_tick_div.sv
// Free-running CLOCK_50 divider producing a one-cycle tick every DIV cycles.
module trim_tick_div #(
   parameter int DIV = 12500000
) (
   input  logic CLOCK_50,
   input  logic RST,
   output logic tick
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DW-1:0] div_cnt;

   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

endmodule

// File: rtl/trim_sweep_gen.sv
// Trim-code sweep generator: serialises CODE_START..CODE_END on ENCLK/DOUT with LATCH and settle.
// Optional TRIM_SHADOW_EN adds the SHADOW port mirroring the trimmed device's shift register.
module trim_sweep_gen
   import trim_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int DIV       = 12500000,
   parameter int SETTLE    = 3,
   parameter int MSB_FIRST = 0
) (
   input  logic             CLOCK_50,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic [WIDTH-1:0] CODE_START,
   input  logic [WIDTH-1:0] CODE_END,
   input  logic [WIDTH-1:0] CODE_STEP,
   output logic             ENCLK,
   output logic             DOUT,
   output logic             LATCH,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] CUR_CODE
`ifdef TRIM_SHADOW_EN
   ,
   output logic [WIDTH-1:0] SHADOW
`endif
);

   localparam int CMAX = (WIDTH > SETTLE) ? WIDTH : SETTLE;
   localparam int CW   = $clog2(CMAX + 1);

   logic             tick;
   ts_state_e        state, state_n;
   logic             phase, phase_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] sr, sr_n;
   logic [WIDTH-1:0] end_r, end_n;
   logic [WIDTH-1:0] step_r, step_n;
   logic [WIDTH-1:0] cur_n;
   logic             enclk_n, dout_n, latch_n, done_n;
   logic             code_done;
   logic [WIDTH:0]   nxt;
   logic             last_code;

   trim_tick_div #(.DIV(DIV)) u_div (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .tick     (tick)
   );

   // One extra bit so a step past 2^WIDTH-1 shows up as overflow instead of wrapping.
   assign nxt       = {1'b0, CUR_CODE} + {1'b0, step_r};
   assign last_code = (CUR_CODE >= end_r) || (nxt > {1'b0, end_r}) || nxt[WIDTH];
   assign BUSY      = (state != TS_IDLE);

   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         state    <= TS_IDLE;
         phase    <= PH_A;
         cnt      <= '0;
         sr       <= '0;
         end_r    <= '0;
         step_r   <= '0;
         CUR_CODE <= '0;
         ENCLK    <= 1'b0;
         DOUT     <= 1'b0;
         LATCH    <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         cnt      <= cnt_n;
         sr       <= sr_n;
         end_r    <= end_n;
         step_r   <= step_n;
         CUR_CODE <= cur_n;
         ENCLK    <= enclk_n;
         DOUT     <= dout_n;
         LATCH    <= latch_n;
         DONE     <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      phase_n   = phase;
      cnt_n     = cnt;
      sr_n      = sr;
      end_n     = end_r;
      step_n    = step_r;
      cur_n     = CUR_CODE;
      enclk_n   = ENCLK;
      dout_n    = DOUT;
      latch_n   = LATCH;
      done_n    = 1'b0;
      code_done = 1'b0;
      if (tick) begin
         enclk_n = 1'b0;
         dout_n  = 1'b0;
         latch_n = 1'b0;
         if (STOP) begin
            state_n = TS_IDLE;
            phase_n = PH_A;
            cnt_n   = '0;
         end else begin
            case (state)
               TS_IDLE: begin
                  if (START) begin
                     end_n   = CODE_END;
                     step_n  = WIDTH'(norm_step(16'(CODE_STEP)));
                     cur_n   = CODE_START;
                     state_n = TS_LOAD;
                  end
               end
               TS_LOAD: begin
                  sr_n    = CUR_CODE;
                  cnt_n   = '0;
                  phase_n = PH_A;
                  state_n = TS_SHIFT;
               end
               TS_SHIFT: begin
                  if (phase == PH_A) begin
                     dout_n  = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
                     phase_n = PH_B;
                  end else begin
                     // DOUT holds through the rising edge so the device sees a full tick of setup and hold.
                     enclk_n = 1'b1;
                     dout_n  = DOUT;
                     phase_n = PH_A;
                     sr_n    = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                     cnt_n   = cnt + 1'b1;
                     if (cnt == CW'(WIDTH - 1)) begin
                        cnt_n   = '0;
                        state_n = TS_LATCH;
                     end
                  end
               end
               TS_LATCH: begin
                  latch_n = 1'b1;
                  if (phase == PH_A) begin
                     phase_n = PH_B;
                  end else begin
                     phase_n = PH_A;
                     if (SETTLE == 0) code_done = 1'b1;
                     else             state_n   = TS_SETTLE;
                  end
               end
               TS_SETTLE: begin
                  if (phase == PH_A) begin
                     phase_n = PH_B;
                  end else begin
                     phase_n = PH_A;
                     cnt_n   = cnt + 1'b1;
                     if (cnt == CW'(SETTLE - 1)) code_done = 1'b1;
                  end
               end
               default: state_n = TS_IDLE;
            endcase
            if (code_done) begin
               cnt_n = '0;
               if (last_code) begin
                  state_n = TS_IDLE;
                  done_n  = 1'b1;
               end else begin
                  cur_n   = nxt[WIDTH-1:0];
                  state_n = TS_LOAD;
               end
            end
         end
      end
   end

`ifdef TRIM_SHADOW_EN
   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST)
         SHADOW <= '0;
      else if (tick && !STOP && state == TS_SHIFT && phase == PH_B)
         SHADOW <= (MSB_FIRST != 0) ? {SHADOW[WIDTH-2:0], DOUT} : {DOUT, SHADOW[WIDTH-1:1]};
   end
`endif

endmodule

// File: tb/tb_trim_sweep_gen.sv
// Scoreboard bench for trim_sweep_gen: three instances (LSB-first, MSB-first, DIV=4).
module tb_trim_sweep_gen;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst = 1'b1;
   logic       start_a = 1'b0, stop_a = 1'b0, start_m = 1'b0, start_d = 1'b0;
   logic [3:0] cs_a = '0, ce_a = '0, cst_a = '0, cs_m = '0, ce_m = '0;

   logic       a_enclk, a_dout, a_latch, a_busy, a_done;
   logic       m_enclk, m_dout, m_latch, m_busy, m_done;
   logic       d_enclk, d_dout, d_latch, d_busy, d_done;
   logic [3:0] a_cur, m_cur, d_cur;
`ifdef TRIM_SHADOW_EN
   logic [3:0] a_sh, m_sh, d_sh;
`endif

   trim_sweep_gen #(.WIDTH(4), .DIV(1), .SETTLE(1), .MSB_FIRST(0)) dut_a (
      .CLOCK_50(clk), .RST(rst), .START(start_a), .STOP(stop_a),
      .CODE_START(cs_a), .CODE_END(ce_a), .CODE_STEP(cst_a),
      .ENCLK(a_enclk), .DOUT(a_dout), .LATCH(a_latch), .BUSY(a_busy), .DONE(a_done),
      .CUR_CODE(a_cur)
`ifdef TRIM_SHADOW_EN
      , .SHADOW(a_sh)
`endif
   );

   trim_sweep_gen #(.WIDTH(4), .DIV(1), .SETTLE(1), .MSB_FIRST(1)) dut_m (
      .CLOCK_50(clk), .RST(rst), .START(start_m), .STOP(1'b0),
      .CODE_START(cs_m), .CODE_END(ce_m), .CODE_STEP(4'd1),
      .ENCLK(m_enclk), .DOUT(m_dout), .LATCH(m_latch), .BUSY(m_busy), .DONE(m_done),
      .CUR_CODE(m_cur)
`ifdef TRIM_SHADOW_EN
      , .SHADOW(m_sh)
`endif
   );

   trim_sweep_gen #(.WIDTH(4), .DIV(4), .SETTLE(1), .MSB_FIRST(0)) dut_d (
      .CLOCK_50(clk), .RST(rst), .START(start_d), .STOP(1'b0),
      .CODE_START(4'd5), .CODE_END(4'd5), .CODE_STEP(4'd1),
      .ENCLK(d_enclk), .DOUT(d_dout), .LATCH(d_latch), .BUSY(d_busy), .DONE(d_done),
      .CUR_CODE(d_cur)
`ifdef TRIM_SHADOW_EN
      , .SHADOW(d_sh)
`endif
   );

   int nvec = 0;
   int nerr = 0;

   // Monitor: rebuilds each serialised code from DOUT at ENCLK rises and logs it at the LATCH rise.
   logic       pe_a = 1'b0, pl_a = 1'b0, pe_m = 1'b0, pl_m = 1'b0;
   logic [3:0] a_bits = '0, m_code = '0;
   int         a_nb = 0, a_rise = 0, a_dn = 0, m_dn = 0, cyc = 0;
   logic [3:0] obs_a[$], obs_m[$], sh_m[$];
   int         lat_a[$];
   int         rd_a = 0, rd_m = 0;

   always @(negedge clk) begin
      cyc  <= cyc + 1;
      pe_a <= a_enclk;
      pl_a <= a_latch;
      pe_m <= m_enclk;
      pl_m <= m_latch;
      if (a_busy !== 1'b1) a_nb <= 0;
      else if (a_enclk && !pe_a) begin
         a_bits[a_nb[1:0]] <= a_dout;
         a_nb <= a_nb + 1;
      end
      if (a_enclk && !pe_a) a_rise <= a_rise + 1;
      if (a_latch && !pl_a) begin
         obs_a.push_back(a_bits);
         lat_a.push_back(cyc);
      end
      if (a_done === 1'b1) a_dn <= a_dn + 1;
      if (m_enclk && !pe_m) m_code <= {m_code[2:0], m_dout};
      if (m_latch && !pl_m) begin
         obs_m.push_back(m_code);
`ifdef TRIM_SHADOW_EN
         sh_m.push_back(m_sh);
`endif
      end
      if (m_done === 1'b1) m_dn <= m_dn + 1;
   end

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      nvec++;
      if ({a_enclk, a_dout, a_latch, a_busy, a_done, a_cur} !== 9'b0) begin
         nerr++;
         $display("FAIL reset_outputs_a got %b want %b", {a_enclk, a_dout, a_latch, a_busy, a_done, a_cur}, 9'b0);
      end
      nvec++;
      if ({m_busy, m_cur, d_busy, d_cur, d_enclk} !== 11'b0) begin
         nerr++;
         $display("FAIL reset_outputs_md got %b want %b", {m_busy, m_cur, d_busy, d_cur, d_enclk}, 11'b0);
      end
`ifdef TRIM_SHADOW_EN
      nvec++;
      if (a_sh !== 4'd0) begin
         nerr++;
         $display("FAIL reset_shadow got %0d want 0", a_sh);
      end
`endif
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      nvec++;
      if (a_busy !== 1'b0) begin
         nerr++;
         $display("FAIL idle_without_start busy got %b want 0", a_busy);
      end
   endtask

   task automatic test_basic_sweep;
      logic [3:0] exp_q[$];
      logic [3:0] e;
      int d0, r0, l0, n, first;
      d0 = a_dn; r0 = a_rise; l0 = lat_a.size(); first = 0; n = 0;
      cs_a = 4'd3; ce_a = 4'd5; cst_a = 4'd1;
      exp_q.push_back(4'd3); exp_q.push_back(4'd4); exp_q.push_back(4'd5);
      start_a = 1'b1;
      @(negedge clk); #1; n = 1;
      start_a = 1'b0;
      while (a_dn == d0 && n < 300) begin
         if (first == 0 && a_rise != r0) first = n;
         @(negedge clk); #1; n++;
      end
      nvec++;
      if (a_dn == d0) begin
         nerr++;
         $display("FAIL basic_done_timeout got no DONE want DONE within 300 cycles");
      end
      nvec++;
      if (first != 4) begin
         nerr++;
         $display("FAIL basic_first_enclk_latency got %0d want 4 cycles", first);
      end
      repeat (4) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         nvec++;
         if (rd_a >= obs_a.size()) begin
            nerr++;
            $display("FAIL basic_code missing want %0d", e);
         end else if (obs_a[rd_a] !== e) begin
            nerr++;
            $display("FAIL basic_code got %0d want %0d", obs_a[rd_a], e);
         end
         rd_a++;
      end
      nvec++;
      if (a_dn - d0 != 1 || a_rise - r0 != 12 || lat_a.size() - l0 != 3) begin
         nerr++;
         $display("FAIL basic_counts got done=%0d rises=%0d latches=%0d want 1 12 3",
                  a_dn - d0, a_rise - r0, lat_a.size() - l0);
      end else begin
         nvec++;
         if (lat_a[l0+1] - lat_a[l0] != 13 || lat_a[l0+2] - lat_a[l0+1] != 13) begin
            nerr++;
            $display("FAIL basic_code_period got %0d,%0d want 13",
                     lat_a[l0+1] - lat_a[l0], lat_a[l0+2] - lat_a[l0+1]);
         end
      end
      nvec++;
      if (a_busy !== 1'b0 || a_cur !== 4'd5) begin
         nerr++;
         $display("FAIL basic_end_state got busy=%b cur=%0d want busy=0 cur=5", a_busy, a_cur);
      end
   endtask

   task automatic test_step_overflow;
      logic [3:0] exp_q[$];
      logic [3:0] e;
      int d0, n;
      for (int run = 0; run < 2; run++) begin
         d0 = a_dn; n = 0;
         if (run == 0) begin
            cs_a = 4'd13; ce_a = 4'd15; cst_a = 4'd2;
            exp_q.push_back(4'd13); exp_q.push_back(4'd15);
         end else begin
            cs_a = 4'd15; ce_a = 4'd15; cst_a = 4'd0;
            exp_q.push_back(4'd15);
         end
         start_a = 1'b1;
         @(negedge clk); #1;
         start_a = 1'b0;
         while (a_dn == d0 && n < 300) begin
            @(negedge clk); #1; n++;
         end
         repeat (4) @(negedge clk);
         #1;
         nvec++;
         if (a_dn - d0 != 1) begin
            nerr++;
            $display("FAIL step_done_count run%0d got %0d want 1", run, a_dn - d0);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nvec++;
            if (rd_a >= obs_a.size()) begin
               nerr++;
               $display("FAIL step_code run%0d missing want %0d", run, e);
            end else if (obs_a[rd_a] !== e) begin
               nerr++;
               $display("FAIL step_code run%0d got %0d want %0d", run, obs_a[rd_a], e);
            end
            rd_a++;
         end
         nvec++;
         if (obs_a.size() != rd_a || a_busy !== 1'b0) begin
            nerr++;
            $display("FAIL step_no_extra run%0d got codes=%0d busy=%b want codes=%0d busy=0",
                     run, obs_a.size(), a_busy, rd_a);
         end
      end
   endtask

   task automatic test_start_above_end;
      int d0, r0, n;
      d0 = a_dn; r0 = a_rise; n = 0;
      cs_a = 4'd9; ce_a = 4'd2; cst_a = 4'd1;
      start_a = 1'b1;
      @(negedge clk); #1;
      start_a = 1'b0;
      while (a_dn == d0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      repeat (4) @(negedge clk);
      #1;
      nvec++;
      if (obs_a.size() != rd_a + 1) begin
         nerr++;
         $display("FAIL above_end_code_count got %0d want 1", obs_a.size() - rd_a);
      end else if (obs_a[rd_a] !== 4'd9) begin
         nerr++;
         $display("FAIL above_end_code got %0d want 9", obs_a[rd_a]);
      end
      rd_a = obs_a.size();
      nvec++;
      if (a_dn - d0 != 1 || a_rise - r0 != 4) begin
         nerr++;
         $display("FAIL above_end_counts got done=%0d rises=%0d want 1 4", a_dn - d0, a_rise - r0);
      end
   endtask

   task automatic test_abort;
      int d0, r0, n;
      d0 = a_dn; r0 = a_rise; n = 0;
      cs_a = 4'd4; ce_a = 4'd9; cst_a = 4'd1;
      start_a = 1'b1;
      @(negedge clk); #1;
      start_a = 1'b0;
      while (a_rise - r0 < 2 && n < 100) begin
         @(negedge clk); #1; n++;
      end
      stop_a = 1'b1;
      @(negedge clk); #1;
      nvec++;
      if ({a_busy, a_enclk, a_dout, a_latch} !== 4'b0 || a_cur !== 4'd4) begin
         nerr++;
         $display("FAIL abort_outputs got busy/enclk/dout/latch=%b cur=%0d want 0000 cur=4",
                  {a_busy, a_enclk, a_dout, a_latch}, a_cur);
      end
      stop_a = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      nvec++;
      if (a_dn != d0 || a_busy !== 1'b0 || obs_a.size() != rd_a || a_cur !== 4'd4) begin
         nerr++;
         $display("FAIL abort_quiet got done=%0d busy=%b codes=%0d cur=%0d want 0 0 0 4",
                  a_dn - d0, a_busy, obs_a.size() - rd_a, a_cur);
      end
      rd_a = obs_a.size();
   endtask

   task automatic test_msb_first;
      int d0, n;
      d0 = m_dn; n = 0;
      cs_m = 4'd6; ce_m = 4'd6;
      start_m = 1'b1;
      @(negedge clk); #1;
      start_m = 1'b0;
      while (m_dn == d0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      nvec++;
      if (obs_m.size() != rd_m + 1) begin
         nerr++;
         $display("FAIL msb_code_count got %0d want 1", obs_m.size() - rd_m);
      end else begin
         if (obs_m[rd_m] !== 4'b0110) begin
            nerr++;
            $display("FAIL msb_bits got %b want 0110", obs_m[rd_m]);
         end
`ifdef TRIM_SHADOW_EN
         nvec++;
         if (sh_m[rd_m] !== 4'd6) begin
            nerr++;
            $display("FAIL msb_shadow got %0d want 6", sh_m[rd_m]);
         end
`endif
      end
      rd_m = obs_m.size();
      nvec++;
      if (m_cur !== 4'd6 || m_dn - d0 != 1) begin
         nerr++;
         $display("FAIL msb_end got cur=%0d done=%0d want 6 1", m_cur, m_dn - d0);
      end
   endtask

   task automatic test_back_to_back;
      int d0, l0, n;
      d0 = a_dn; l0 = lat_a.size(); n = 0;
      cs_a = 4'd7; ce_a = 4'd7; cst_a = 4'd1;
      start_a = 1'b1;
      while (a_dn - d0 < 2 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      nvec++;
      if (a_dn - d0 != 2 || lat_a.size() - l0 != 2) begin
         nerr++;
         $display("FAIL b2b_counts got done=%0d latches=%0d want 2 2", a_dn - d0, lat_a.size() - l0);
      end else begin
         nvec++;
         if (obs_a[rd_a] !== 4'd7 || obs_a[rd_a+1] !== 4'd7) begin
            nerr++;
            $display("FAIL b2b_codes got %0d,%0d want 7,7", obs_a[rd_a], obs_a[rd_a+1]);
         end
         nvec++;
         if (lat_a[l0+1] - lat_a[l0] != 14) begin
            nerr++;
            $display("FAIL b2b_restart_gap got %0d want 14", lat_a[l0+1] - lat_a[l0]);
         end
      end
      rd_a = obs_a.size();
      nvec++;
      if (a_busy !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_stops_when_released got busy=%b want 0", a_busy);
      end
   endtask

   task automatic test_reset_div;
      logic seen_hi, pe;
      int n, busy_at, r1, r2;
      seen_hi = 1'b0; n = 0;
      start_d = 1'b1;
      while (!(seen_hi && d_latch === 1'b0) && n < 400) begin
         if (d_busy === 1'b1) start_d = 1'b0;
         if (d_latch === 1'b1) seen_hi = 1'b1;
         @(negedge clk); #1; n++;
      end
      nvec++;
      if (!seen_hi || d_busy !== 1'b1 || d_cur !== 4'd5) begin
         nerr++;
         $display("FAIL div_reach_settle got latch_seen=%b busy=%b cur=%0d want 1 1 5", seen_hi, d_busy, d_cur);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if ({d_enclk, d_dout, d_latch, d_busy, d_done, d_cur} !== 9'b0) begin
         nerr++;
         $display("FAIL div_async_reset got %b want %b", {d_enclk, d_dout, d_latch, d_busy, d_done, d_cur}, 9'b0);
      end
      start_d = 1'b1;
      #2;
      rst = 1'b0;
      busy_at = 0; r1 = 0; r2 = 0; pe = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk); #1;
         if (busy_at == 0 && d_busy === 1'b1) begin
            busy_at = i;
            start_d = 1'b0;
         end
         if (d_enclk === 1'b1 && !pe) begin
            if (r1 == 0) r1 = i;
            else if (r2 == 0) r2 = i;
         end
         pe = d_enclk;
      end
      nvec++;
      if (busy_at != 4) begin
         nerr++;
         $display("FAIL div_first_tick got busy at cycle %0d want 4", busy_at);
      end
      nvec++;
      if (r1 != 16 || r2 != 24) begin
         nerr++;
         $display("FAIL div_enclk_rises got %0d,%0d want 16,24", r1, r2);
      end
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_step_overflow();
      test_start_above_end();
      test_abort();
      test_msb_first();
      test_back_to_back();
      test_reset_div();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/trim_sweep_gen.md
# trim_sweep_gen

- Parametrised trim-code sweep generator.
- Steps a `WIDTH`-bit trim code from `CODE_START` to `CODE_END` by `CODE_STEP`.
- Serialises each code to the device under trim on a gated `ENCLK`/`DOUT` pair, pulses `LATCH` after each code, then waits a settle interval before the next code.
- Runs entirely in the `CLOCK_50` domain using a tick strobe; there are no derived clocks. Replaces the fixed 12-bit, full-range, divided-clock trim generator on the board top level.

## Interface
Parameters:
- `WIDTH`, 12 — trim code width in bits (2..16).
- `DIV`, 12500000 — `CLOCK_50` cycles per tick (≥1); one bit period is 2 ticks.
- `SETTLE`, 3 — bit periods of idle wait after `LATCH` (≥0).
- `MSB_FIRST`, 0 — 1: shift MSB first; 0: shift LSB first.

Ports:
- `CLOCK_50` in 1 — single clock.
- `RST` in 1 — asynchronous, active-high reset.
- `START` in 1 — level; sampled on tick; starts a sweep from IDLE.
- `STOP` in 1 — level; sampled on tick; aborts the sweep.
- `CODE_START` in `WIDTH` — first code; captured at start.
- `CODE_END` in `WIDTH` — last code; captured at start.
- `CODE_STEP` in `WIDTH` — increment; captured at start; 0 is treated as 1.
- `ENCLK` out 1 — serial clock to the DUT, registered.
- `DOUT` out 1 — serial data, registered.
- `LATCH` out 1 — high for one bit period after the last bit of each code.
- `BUSY` out 1 — high in every state except IDLE.
- `DONE` out 1 — one-`CLOCK_50`-cycle pulse at normal sweep completion.
- `CUR_CODE` out `WIDTH` — code currently being shifted or held.
- `SHADOW` out `WIDTH` — only with `TRIM_SHADOW_EN`; see Configuration.

## Operation
- **Tick generation:** a divider counter runs 0..`DIV`-1. `tick` is asserted for one cycle when the count equals `DIV`-1. All state, `ENCLK` and `DOUT` updates occur only on tick cycles.
- **Bit period:** phase A tick drives `ENCLK`=0 and updates `DOUT`; phase B tick drives `ENCLK`=1. The DUT samples on the `ENCLK` rising edge, so `DOUT` is stable for a full tick on both sides of that edge.
- **States:** IDLE → LOAD → SHIFT → LATCH → SETTLE → (LOAD | IDLE).
  - **IDLE:** `ENCLK`=0, `DOUT`=0. If `START`=1 on a tick: capture the three code inputs, set `CUR_CODE`=`CODE_START`, go to LOAD.
  - **LOAD:** lasts 1 tick. Copies `CUR_CODE` into the shift register and clears the bit counter.
  - **SHIFT:** `WIDTH` bit periods. Bit order is LSB→MSB, or MSB→LSB when `MSB_FIRST`=1.
  - **LATCH:** 1 bit period with `LATCH`=1, `ENCLK`=0, `DOUT`=0.
  - **SETTLE:** `SETTLE` bit periods with outputs idle. This state is skipped when `SETTLE`=0.
- **End of SETTLE:** compute next = `CUR_CODE` + step in `WIDTH`+1 bits.
  - If `CUR_CODE` ≥ `CODE_END`, or next > `CODE_END`, or next overflows `WIDTH` bits: go to IDLE and pulse `DONE`.
  - Otherwise set `CUR_CODE`=next and go to LOAD.
- **Boundary cases:**
  - `CODE_START` > `CODE_END`: exactly one code (`CODE_START`) is sent, then `DONE`.
  - `CODE_START` = `CODE_END` = 2^`WIDTH`-1: one code is sent; there is no wrap-around to 0.
- **START handling:** `START` while BUSY is ignored. `START` held high after `DONE` restarts the sweep on the next tick, which gives a continuous sweep.
- **STOP:** takes priority over every state transition. On the next tick it forces IDLE, `ENCLK`=0, `DOUT`=0, `LATCH`=0, with no `DONE` pulse. `CUR_CODE` holds its last value.
- **Reset:** `RST` mid-operation clears the divider, state, counters and every output immediately.
- **Reset values:** `ENCLK`=0, `DOUT`=0, `LATCH`=0, `BUSY`=0, `DONE`=0, `CUR_CODE`=0, `SHADOW`=0.

## Timing
- Every tick-driven output changes one `CLOCK_50` cycle after its tick (registered). `DONE` is the exception: it is high exactly on the cycle after the completing tick.
- Ticks per code: 1 + 2·`WIDTH` + 2 + 2·`SETTLE`.
- Latency: `START` sampled on tick *n* → LOAD at tick *n*+1 → first `DOUT` bit at tick *n*+2.
- `ENCLK` has exactly `WIDTH` rising edges per code and none outside SHIFT.

## Configuration
- Macro `TRIM_SHADOW_EN`.
- **Defined:** adds port `SHADOW`, a `WIDTH`-bit shift register in the `CLOCK_50` domain. It shifts `DOUT` in on each phase B tick during SHIFT, mirroring the DUT register so it holds `CUR_CODE` once LATCH begins. It is cleared by `RST` only.
- **Undefined:** the `SHADOW` port and its logic are absent. All other behaviour is identical.

## Structure
- The shared package `trim_pkg` holds:
  - the state enum (`TS_IDLE`, `TS_LOAD`, `TS_SHIFT`, `TS_LATCH`, `TS_SETTLE`);
  - the tick-phase constants;
  - a step-normalisation function (0→1).
- Sub-module `trim_tick_div` (parameter `DIV`; ports `CLOCK_50`, `RST`, `tick`) contains the divider. The rest is one FSM plus datapath.
- The existing `bin2bcd`/`bcd2disp` instances stay at the top level and are driven by `CUR_CODE`.

## Test plan
Unless noted, benches use `WIDTH`=4, `DIV`=1, `SETTLE`=1, `MSB_FIRST`=0.
- **Basic sweep:** start=3, end=5, step=1, `START` pulse → codes 3,4,5. `DOUT` at each `ENCLK` rise: 1100, 0010, 1010. 3 `LATCH` pulses, 13 cycles per code, 1 `DONE` pulse.
- **MSB first:** `MSB_FIRST`=1, start=end=6 → `DOUT` bits 0110. `SHADOW`=6 at `LATCH` (with `TRIM_SHADOW_EN`).
- **Step and overflow:** start=13, end=15, step=2 → codes 13,15, then `DONE`. A second run with start=15, end=15, step=0 → code 15 only, no wrap.
- **Start above end:** start=9, end=2 → single code 9, then `DONE`.
- **Abort:** `STOP` asserted mid-SHIFT of code 4 → next cycle IDLE, `ENCLK`=0, `DOUT`=0, no `DONE`, `CUR_CODE`=4.
- **Reset and divider:** `RST` asserted during SETTLE → all outputs 0 asynchronously. After release with `DIV`=4, tick spacing is 4 cycles and the first `ENCLK` rise falls within the expected window.
